ex_stage_md: RTL

Parametrised execute stage with forwarding muxes, a registered EX/MEM output bank, and an iterative multiply/divide unit with HI/LO registers. Sits between the ID/EX register and the memory stage of the MIPS pipeline. Single-cycle ALU ops retire in one cycle. MULT/MULTU/DIV/DIVU stall upstream via `o_stall` for NB_DATA+1 cycles.

---
 rtl/ex_pkg.sv | 13 +
 rtl/ex_stage_md_muldiv.sv | 78 +++++++
 rtl/ex_stage_md.sv | 129 ++++++++++++
 3 files changed

// File: rtl/ex_pkg.sv
// ex_pkg: shared ALU op codes, funct codes, forwarding selects and mul/div FSM states
package ex_pkg;
  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_RTYPE = 3'd2, ALU_AND = 3'd3,
                         ALU_OR = 3'd4, ALU_XOR = 3'd5, ALU_LUI = 3'd6, ALU_SLT = 3'd7;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_SLLV = 6'h04,
                         F_SRLV = 6'h06, F_SRAV = 6'h07, F_MFHI = 6'h10, F_MFLO = 6'h12,
                         F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B,
                         F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23,
                         F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27,
                         F_SLT = 6'h2A, F_SLTU = 6'h2B;
  localparam logic [1:0] FWD_MEM = 2'd1, FWD_WB = 2'd2;
  typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;
endpackage

// File: rtl/ex_stage_md_muldiv.sv
// muldiv_unit: iterative shift-add multiplier / restoring divider with HI/LO and sign fix-up
module muldiv_unit import ex_pkg::*; #(
  parameter int NB_DATA = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               ack,
  input  logic [1:0]         op,
  input  logic [NB_DATA-1:0] a,
  input  logic [NB_DATA-1:0] b,
  output logic               busy,
  output logic               done,
  output logic [NB_DATA-1:0] hi,
  output logic [NB_DATA-1:0] lo
);
  localparam int CW = $clog2(NB_DATA + 1);
  md_state_t state;
  logic [CW-1:0] count;
  logic is_div, neg_a, neg_b, sgn;
  logic [NB_DATA-1:0] a_raw, d, acc_hi, acc_lo, fix_hi, fix_lo, q;
  logic [NB_DATA:0] sum, sh, tr;
  logic [2*NB_DATA-1:0] prod;
  assign sgn = !op[0];
  assign sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, d} : '0);
  assign sh = {acc_hi, acc_lo[NB_DATA-1]};
  assign tr = sh - {1'b0, d};
  assign prod = neg_a ^ neg_b ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
  assign q = neg_a ^ neg_b ? -acc_lo : acc_lo;
  assign fix_lo = !is_div ? prod[NB_DATA-1:0] : d == '0 ? '1 : q;
  assign fix_hi = !is_div ? prod[2*NB_DATA-1:NB_DATA] : d == '0 ? a_raw : neg_a ? -acc_hi : acc_hi;
  assign busy = state == MD_BUSY;
  assign done = state == MD_DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MD_IDLE;
      count <= '0;
      is_div <= 1'b0;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
      a_raw <= '0;
      d <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      hi <= '0;
      lo <= '0;
    end else if (abort) begin
      state <= MD_IDLE;
    end else begin
      case (state)
        MD_IDLE: if (start) begin
          state <= MD_BUSY;
          count <= '0;
          is_div <= op[1];
          neg_a <= sgn & a[NB_DATA-1];
          neg_b <= sgn & b[NB_DATA-1];
          a_raw <= a;
          d <= sgn & b[NB_DATA-1] ? -b : b;
          acc_hi <= '0;
          acc_lo <= sgn & a[NB_DATA-1] ? -a : a;
        end
        MD_BUSY: begin
          count <= count + CW'(1);
          state <= count == CW'(NB_DATA - 1) ? MD_DONE : MD_BUSY;
          acc_hi <= is_div ? (tr[NB_DATA] ? sh[NB_DATA-1:0] : tr[NB_DATA-1:0]) : sum[NB_DATA:1];
          acc_lo <= is_div ? {acc_lo[NB_DATA-2:0], !tr[NB_DATA]} : {sum[0], acc_lo[NB_DATA-1:1]};
        end
        MD_DONE: if (ack) begin
          hi <= fix_hi;
          lo <= fix_lo;
          state <= MD_IDLE;
        end
        default: state <= MD_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/ex_stage_md.sv
// ex_stage_md: MIPS execute stage with forwarding, ALU, iterative mul/div and EX/MEM register bank
module ex_stage_md import ex_pkg::*; #(
  parameter int NB_DATA = 32,
  parameter int NB_PC = 32,
  parameter int NB_REG = 5,
  parameter int NB_ALU_OP = 3,
  parameter int NB_FCODE = 6
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_valid,
  input  logic                 i_flush,
  input  logic                 i_hold,
  input  logic                 i_reg_write,
  input  logic                 i_mem_to_reg,
  input  logic                 i_mem_read,
  input  logic                 i_mem_write,
  input  logic                 i_branch,
  input  logic                 i_alu_src,
  input  logic                 i_reg_dst,
  input  logic [NB_ALU_OP-1:0] i_alu_op,
  input  logic [NB_PC-1:0]     i_pc,
  input  logic [NB_DATA-1:0]   i_data_a,
  input  logic [NB_DATA-1:0]   i_data_b,
  input  logic [NB_DATA-1:0]   i_immediate,
  input  logic [NB_REG-1:0]    i_rt,
  input  logic [NB_REG-1:0]    i_rd,
  input  logic [1:0]           i_fwd_a,
  input  logic [1:0]           i_fwd_b,
  input  logic [NB_DATA-1:0]   i_mem_fwd,
  input  logic [NB_DATA-1:0]   i_wb_fwd,
  output logic                 o_stall,
  output logic                 o_valid,
  output logic                 o_reg_write,
  output logic                 o_mem_to_reg,
  output logic                 o_mem_read,
  output logic                 o_mem_write,
  output logic                 o_branch,
  output logic [NB_DATA-1:0]   o_alu_result,
  output logic [NB_DATA-1:0]   o_store_data,
  output logic [NB_PC-1:0]     o_branch_address,
  output logic                 o_zero,
  output logic [NB_REG-1:0]    o_selected_reg
);
  localparam int SH = $clog2(NB_DATA);
  logic [NB_DATA-1:0] op_a, fwd_b, op_b, alu_res, hi, lo;
  logic [5:0] funct;
  logic [SH-1:0] sh_amt;
  logic md_op, start, busy, done, md_stall;
  assign funct = 6'(i_immediate[NB_FCODE-1:0]);
  assign op_a = i_fwd_a == FWD_MEM ? i_mem_fwd : i_fwd_a == FWD_WB ? i_wb_fwd : i_data_a;
  assign fwd_b = i_fwd_b == FWD_MEM ? i_mem_fwd : i_fwd_b == FWD_WB ? i_wb_fwd : i_data_b;
  assign op_b = i_alu_src ? i_immediate : fwd_b;
  assign md_op = i_alu_op == ALU_RTYPE && (funct == F_MULT || funct == F_MULTU || funct == F_DIV || funct == F_DIVU);
  assign start = i_valid & md_op & !i_flush;
  assign md_stall = busy | (start & !done);
  assign o_stall = (i_hold & !i_flush) | md_stall;
  assign sh_amt = funct[2] ? op_a[SH-1:0] : i_immediate[NB_FCODE +: SH];
  always_comb begin
    alu_res = '0;
    case (i_alu_op)
      ALU_ADD: alu_res = op_a + op_b;
      ALU_SUB: alu_res = op_a - op_b;
      ALU_AND: alu_res = op_a & op_b;
      ALU_OR:  alu_res = op_a | op_b;
      ALU_XOR: alu_res = op_a ^ op_b;
      ALU_LUI: alu_res = {op_b[NB_DATA/2-1:0], {(NB_DATA/2){1'b0}}};
      ALU_SLT: alu_res = NB_DATA'($signed(op_a) < $signed(op_b));
      ALU_RTYPE: case (funct)
        F_ADD, F_ADDU: alu_res = op_a + op_b;
        F_SUB, F_SUBU: alu_res = op_a - op_b;
        F_AND:  alu_res = op_a & op_b;
        F_OR:   alu_res = op_a | op_b;
        F_XOR:  alu_res = op_a ^ op_b;
        F_NOR:  alu_res = ~(op_a | op_b);
        F_SLT:  alu_res = NB_DATA'($signed(op_a) < $signed(op_b));
        F_SLTU: alu_res = NB_DATA'(op_a < op_b);
        F_SLL, F_SLLV: alu_res = op_b << sh_amt;
        F_SRL, F_SRLV: alu_res = op_b >> sh_amt;
        F_SRA, F_SRAV: alu_res = $signed(op_b) >>> sh_amt;
        F_MFHI: alu_res = hi;
        F_MFLO: alu_res = lo;
        default: alu_res = '0;
      endcase
      default: alu_res = '0;
    endcase
  end
  muldiv_unit #(.NB_DATA(NB_DATA)) u_md (
    .clk(i_clock),
    .rst(i_reset),
    .start(start),
    .abort(i_flush),
    .ack(!i_hold),
    .op(funct[1:0]),
    .a(op_a),
    .b(fwd_b),
    .busy(busy),
    .done(done),
    .hi(hi),
    .lo(lo)
  );
  always_ff @(posedge i_clock) begin
    if (i_reset || i_flush || (!i_hold && (md_stall || !i_valid))) begin
      o_valid <= 1'b0;
      o_reg_write <= 1'b0;
      o_mem_to_reg <= 1'b0;
      o_mem_read <= 1'b0;
      o_mem_write <= 1'b0;
      o_branch <= 1'b0;
      o_alu_result <= '0;
      o_store_data <= '0;
      o_branch_address <= '0;
      o_zero <= 1'b0;
      o_selected_reg <= '0;
    end else if (!i_hold) begin
      o_valid <= 1'b1;
      o_reg_write <= i_reg_write;
      o_mem_to_reg <= i_mem_to_reg;
      o_mem_read <= i_mem_read;
      o_mem_write <= i_mem_write;
      o_branch <= i_branch;
      o_alu_result <= alu_res;
      o_store_data <= fwd_b;
      o_branch_address <= i_pc + NB_PC'({i_immediate, 2'b00});
      o_zero <= alu_res == '0;
      o_selected_reg <= i_reg_dst ? i_rd : i_rt;
    end
  end
endmodule
